// File: rtl/rtc_pkg.sv
// Shared constants for the RTC DIR_DATO bus sequencer: modes, frame timing and
// the register address table in wr_bus/rd_bus byte order.
package rtc_pkg;

    localparam int         N_REGS      = 9;
    localparam logic [4:0] ADDR_LO     = 5'd1;
    localparam logic [4:0] ADDR_HI     = 5'd10;
    localparam logic [4:0] DATA_LO     = 5'd20;
    localparam logic [4:0] DATA_HI     = 5'd26;
    localparam logic [4:0] RD_SAMPLE   = 5'd25;
    localparam logic [4:0] FRAME_LAST  = 5'd31;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_READ   = 2'b01;
    localparam logic [1:0] MODE_WRITE  = 2'b10;
    localparam logic [1:0] MODE_STATUS = 2'b11;

    localparam logic [7:0] CMD_ADDR    = 8'hF0;
    localparam logic [7:0] CMD_DATA    = 8'hF0;
    localparam logic [7:0] STATUS_ADDR = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // dia, mes, ano, seg, min, hora, segcr, mincr, horacr
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h24;
            4'd1:    return 8'h25;
            4'd2:    return 8'h26;
            4'd3:    return 8'h21;
            4'd4:    return 8'h22;
            4'd5:    return 8'h23;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            4'd8:    return 8'h43;
            default: return CMD_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_driver.sv
// DIR_DATO tri-state driver with a one-byte input sample register and a
// matching one-cycle valid flag.
module rtc_bus_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic       drive_en,
    input  logic [7:0] drive_val,
    input  logic       sample_en,
    output logic [7:0] sample_q,
    output logic       sample_vld_q,
    inout  wire  [7:0] dir_dato
);

    logic [7:0] sample_d;
    logic       sample_vld_d;

    assign dir_dato = drive_en ? drive_val : 8'bzzzz_zzzz;

    always_comb begin
        sample_d     = sample_q;
        sample_vld_d = sample_en;
        if (sample_en) begin
            sample_d = dir_dato;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q     <= 8'h00;
            sample_vld_q <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
        end
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Per-frame address/data sequencer on DIR_DATO, driven by the handshake
// machine's mode and 32-cycle frame counter.
//   state    | meaning
//   ST_IDLE  | between frames, or no mode latched
//   ST_FRAME | frame in progress (cont_32c 1..31)
//   ST_HOLD  | write/status sequence finished, waiting for control to change
import rtc_pkg::*;

module rtc_bus_sequencer (
    input  logic        reloj,
    input  logic        resetM,
    input  logic [1:0]  control,
    input  logic [4:0]  cont_32c,
    input  logic [71:0] wr_bus,
    input  logic [7:0]  status_byte,
    output logic [71:0] rd_bus,
    output logic [8:0]  rd_valid,
    output logic        busy,
    output logic        seq_done,
    inout  wire  [7:0]  DIR_DATO
);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  idx_q, idx_d;
    logic [71:0] snap_q, snap_d;
    logic [7:0]  stat_q, stat_d;
    logic [71:0] rd_q, rd_d;
    logic [8:0]  rdv_q, rdv_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        mode_chg;
    logic [3:0]  last_idx, start_idx;
    logic        in_frame, in_addr, in_data, drive_en, sample_en;
    logic [7:0]  addr_val, data_val, drive_val;
    logic [7:0]  sample_q;
    logic        sample_vld_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        stat_d    = stat_q;
        rd_d      = rd_q;
        rdv_d     = 9'd0;
        done_d    = 1'b0;
        mode_chg  = (control != mode_q);
        last_idx  = (control == MODE_READ) ? 4'(N_REGS - 1) : 4'(N_REGS);
        start_idx = (mode_chg || idx_q > last_idx) ? 4'd0 : idx_q;

        if (cont_32c == 5'd0 && state_q != ST_FRAME) begin
            mode_d = control;
            idx_d  = start_idx;
            if (control == MODE_IDLE) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_HOLD && !mode_chg) begin
                state_d = ST_HOLD;
            end else begin
                // A new mode coinciding with frame start begins in this frame.
                state_d = ST_FRAME;
                stat_d  = status_byte;
                if (control == MODE_WRITE && start_idx == 4'd0) begin
                    snap_d = wr_bus;
                end
            end
        end else if (cont_32c == FRAME_LAST && state_q == ST_FRAME) begin
            state_d = ST_IDLE;
            case (mode_q)
                MODE_READ: idx_d = (idx_q >= 4'(N_REGS - 1)) ? 4'd0 : idx_q + 4'd1;
                MODE_WRITE: begin
                    if (idx_q >= 4'(N_REGS)) begin
                        state_d = ST_HOLD;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                MODE_STATUS: begin
                    state_d = ST_HOLD;
                    idx_d   = 4'd0;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (sample_vld_q && idx_q < 4'(N_REGS)) begin
            rd_d[{idx_q, 3'b000} +: 8] = sample_q;
            rdv_d[idx_q]               = 1'b1;
        end
        busy_d = (state_d == ST_FRAME);
    end

    always_comb begin
        addr_val = STATUS_ADDR;
        data_val = stat_q;
        case (mode_q)
            MODE_READ: begin
                addr_val = reg_addr(idx_q);
                data_val = 8'h00;
            end
            MODE_WRITE: begin
                if (idx_q < 4'(N_REGS)) begin
                    addr_val = reg_addr(idx_q);
                    data_val = snap_q[{idx_q, 3'b000} +: 8];
                end else begin
                    addr_val = CMD_ADDR;
                    data_val = CMD_DATA;
                end
            end
            default: ;
        endcase
    end

    assign in_frame  = (state_q == ST_FRAME) && (mode_q != MODE_IDLE);
    assign in_addr   = in_frame && cont_32c >= ADDR_LO && cont_32c <= ADDR_HI;
    assign in_data   = in_frame && cont_32c >= DATA_LO && cont_32c <= DATA_HI
                       && mode_q != MODE_READ;
    assign drive_en  = in_addr || in_data;
    assign drive_val = in_addr ? addr_val : data_val;
    assign sample_en = in_frame && mode_q == MODE_READ && cont_32c == RD_SAMPLE;

    rtc_bus_driver u_drv (
        .clk          (reloj),
        .rst          (resetM),
        .drive_en     (drive_en),
        .drive_val    (drive_val),
        .sample_en    (sample_en),
        .sample_q     (sample_q),
        .sample_vld_q (sample_vld_q),
        .dir_dato     (DIR_DATO)
    );

    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_IDLE;
            idx_q   <= 4'd0;
            snap_q  <= 72'd0;
            stat_q  <= 8'h00;
            rd_q    <= 72'd0;
            rdv_q   <= 9'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            stat_q  <= stat_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_bus   = rd_q;
    assign rd_valid = rdv_q;
    assign busy     = busy_q;
    assign seq_done = done_q;

endmodule
